// File: rtl/dotp_arbiter_if.sv
// Bundles the requester, engine and response channels of the dot-product arbiter.
// Ports (signals):
//   req, req_a, req_b       requester levels and packed operand vectors
//   gnt                     one-hot accept pulse back to the requesters
//   eng_mem1/2, eng_start   operands and start strobe to the engine
//   eng_result, eng_done    result and completion strobe from the engine
//   rsp_*                   valid/ready response channel
//   busy                    arbiter is outside IDLE
// Modports: slave = arbiter view, master = requester/engine/consumer view.
interface dotp_arbiter_if #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RESULT_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]         eng_mem1;
    logic [DATA_WIDTH-1:0]         eng_mem2;
    logic                          eng_start;
    logic [RESULT_WIDTH-1:0]       eng_result;
    logic                          eng_done;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [RESULT_WIDTH-1:0]       rsp_result;
    logic                          rsp_err;
    logic                          busy;

    modport slave (
        input  req, req_a, req_b, eng_result, eng_done, rsp_ready,
        output gnt, eng_mem1, eng_mem2, eng_start,
               rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    modport master (
        output req, req_a, req_b, eng_result, eng_done, rsp_ready,
        input  gnt, eng_mem1, eng_mem2, eng_start,
               rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/dotp_arbiter.sv
// Round-robin scheduler sharing one dot-product engine among NUM_REQ requesters.
// One transaction at a time: grant, latch operands, pulse engine start, wait for
// done, return the result tagged with the requester id over valid/ready.
// Ports:
//   clk   clock, all logic on posedge
//   rst   asynchronous active-high reset
//   bus   dotp_arbiter_if.slave (requesters, engine, response channel, busy)
// Optional build macro DOTP_ARB_TIMEOUT_EN: adds a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles that returns rsp_err=1 / rsp_result=0 on expiry.
// Without it rsp_err is constant 0 and WAIT lasts until eng_done or reset.
module dotp_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RESULT_WIDTH = 16
`ifdef DOTP_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input logic           clk,
    input logic           rst,
    dotp_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef DOTP_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]   mem1_q, mem1_d;
    logic [DATA_WIDTH-1:0]   mem2_q, mem2_d;
    logic                    start_q, start_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
    logic [RESULT_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                    busy_q, busy_d;
`ifdef DOTP_ARB_TIMEOUT_EN
    logic                    rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W-1:0]        cand;
    logic                    found;
    logic                    any_req;

    // Modular increment of a requester index by an offset, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Per-requester operand views of the packed request buses.
    logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] op_b [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign op_a[g] = bus.req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign op_b[g] = bus.req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First active request at or above rr_ptr, wrapping around.
    always_comb begin : rr_pick
        sel_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            if (!found && bus.req[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign any_req = |bus.req;

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            mem1_q       <= '0;
            mem2_q       <= '0;
            start_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
`ifdef DOTP_ARB_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            mem1_q       <= mem1_d;
            mem2_q       <= mem2_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
`ifdef DOTP_ARB_TIMEOUT_EN
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Next state and next registered-output values.
    always_comb begin : fsm_next
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = '0;
        start_d      = 1'b0;
        mem1_d       = mem1_q;
        mem2_d       = mem2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
`ifdef DOTP_ARB_TIMEOUT_EN
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d    = NUM_REQ'(1) << sel_idx;
                    mem1_d   = op_a[sel_idx];
                    mem2_d   = op_b[sel_idx];
                    rsp_id_d = ID_WIDTH'(sel_idx);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Start becomes visible on the first WAIT cycle.
                start_d = 1'b1;
                state_d = WAIT;
`ifdef DOTP_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.eng_done) begin
                    rsp_result_d = bus.eng_result;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
`ifdef DOTP_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_result_d = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifdef DOTP_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    rr_ptr_d    = wrap_add(IDX_W'(rsp_id_q), 1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.gnt        = gnt_q;
    assign bus.eng_mem1   = mem1_q;
    assign bus.eng_mem2   = mem2_q;
    assign bus.eng_start  = start_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.busy       = busy_q;
`ifdef DOTP_ARB_TIMEOUT_EN
    assign bus.rsp_err    = rsp_err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dotp_arbiter.sv
// Self-checking bench for dotp_arbiter: table-driven transactions, hand-written
// corner sequences (spurious done, reset mid-operation, timeout) and randomized
// transactions checked against a transaction-level round-robin model.
module tb_dotp_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 16;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dotp_arbiter_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();

    dotp_arbiter #(
        .NUM_REQ(NR),
        .ID_WIDTH(IW),
        .DATA_WIDTH(DW),
        .RESULT_WIDTH(RW)
`ifdef DOTP_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;
    int ptr_m  = 0;

    // Engine model state
    bit          eng_auto  = 1'b1;
    bit          eng_armed = 1'b0;
    int          eng_lat   = 1;
    int          eng_cnt   = 0;
    logic [15:0] eng_val   = '0;

    logic [31:0] ops_a [NR];
    logic [31:0] ops_b [NR];

    typedef struct {
        logic [3:0]  req;
        bit          keep;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold;
        int          exp_id;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] dot(input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = 0;
        for (int i = 0; i < 4; i++) s += 32'(a[i*8 +: 8]) * 32'(b[i*8 +: 8]);
        return 16'(s);
    endfunction

    // Round-robin reference: first set bit at or above p, wrapping.
    function automatic int pick(input logic [3:0] r, input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic apply_ops();
        for (int i = 0; i < int'(NR); i++) begin
            bus.req_a[i*32 +: 32] = ops_a[i];
            bus.req_b[i*32 +: 32] = ops_b[i];
        end
    endtask

    // One clock; then the engine model reacts to what it sees.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.eng_done = 1'b0;
        if (eng_armed) begin
            if (eng_cnt <= 1) begin
                bus.eng_done   = 1'b1;
                bus.eng_result = eng_val;
                eng_armed      = 1'b0;
            end else begin
                eng_cnt--;
            end
        end
        if (eng_auto && bus.eng_start === 1'b1) begin
            eng_armed = 1'b1;
            eng_cnt   = eng_lat;
            eng_val   = dot(bus.eng_mem1, bus.eng_mem2);
        end
    endtask

    function automatic logic any_out();
        return |{bus.gnt, bus.eng_mem1, bus.eng_mem2, bus.eng_start, bus.rsp_valid,
                 bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.busy};
    endfunction

    // Full transaction from IDLE: grant, start, wait for engine, backpressure, handshake.
    task automatic run_txn(input logic [3:0] reqv, input bit keep, input int lat,
                           input int hold, input int exp_id, input logic [15:0] exp_res,
                           input string tag);
        logic [3:0] exp_g;
        int         n;
        bit         bad;
        exp_g = 4'(1) << exp_id;
        eng_lat  = lat;
        eng_auto = 1'b1;
        bus.req  = reqv;
        bus.rsp_ready = 1'b0;
        tick();
        check({tag, ".gnt"}, {bus.gnt, bus.busy}, {exp_g, 1'b1});
        if (!keep) bus.req = reqv & ~exp_g;
        tick();
        check({tag, ".issue"}, {bus.gnt, bus.eng_start}, {4'b0000, 1'b1});
        check({tag, ".ops"}, {bus.eng_mem1, bus.eng_mem2}, {ops_a[exp_id], ops_b[exp_id]});
        n   = 0;
        bad = 1'b0;
        while (bus.rsp_valid !== 1'b1 && n < lat + 6) begin
            tick();
            n++;
            if (bus.gnt !== 4'b0000 || bus.eng_start !== 1'b0) bad = 1'b1;
        end
        check({tag, ".lat"}, 64'(n), 64'(lat + 1));
        check({tag, ".rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err},
              {1'b1, 2'(exp_id), exp_res, 1'b0});
        for (int h = 0; h < hold; h++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(exp_id) ||
                bus.rsp_result !== exp_res || bus.gnt !== 4'b0000 ||
                bus.eng_start !== 1'b0) bad = 1'b1;
        end
        check({tag, ".quiet"}, 64'(bad), 64'(0));
        bus.rsp_ready = 1'b1;
        tick();
        check({tag, ".hs"}, {bus.rsp_valid, bus.busy}, 2'b00);
        bus.rsp_ready = 1'b0;
        ptr_m = (exp_id + 1) % 4;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [3:0]  pending;
        logic [3:0]  newr;
        int          id;
        int          n;
        bit          bad;

        rst            = 1'b1;
        bus.req        = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.eng_result = '0;
        bus.eng_done   = 1'b0;
        bus.rsp_ready  = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            ops_a[i] = '0;
            ops_b[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(any_out()), 64'(0));
        rst = 1'b0;
        tick();
        check("idle_after_reset", {bus.busy, bus.gnt}, 5'b0);

        // Table: round robin, single request, backpressure, back-to-back grant.
        vecs[0] = '{4'b1111, 1'b1, 32'h05060708, 32'h05060708, 1, 0, 0, 16'd174};
        vecs[1] = '{4'b1111, 1'b1, 32'h05060708, 32'h05060708, 2, 0, 1, 16'd174};
        vecs[2] = '{4'b1111, 1'b1, 32'h05060708, 32'h05060708, 3, 0, 2, 16'd174};
        vecs[3] = '{4'b1111, 1'b1, 32'h05060708, 32'h05060708, 1, 0, 3, 16'd174};
        vecs[4] = '{4'b1111, 1'b1, 32'h05060708, 32'h05060708, 2, 0, 0, 16'd174};
        vecs[5] = '{4'b1111, 1'b0, 32'h05060708, 32'h05060708, 1, 0, 1, 16'd174};
        vecs[6] = '{4'b0100, 1'b0, 32'h01020304, 32'h01020304, 2, 0, 2, 16'd30};
        vecs[7] = '{4'b0011, 1'b0, 32'h03030303, 32'h04050405, 3, 5, 0, 16'd54};
        vecs[8] = '{4'b0010, 1'b0, 32'h03030303, 32'h04050405, 2, 1, 1, 16'd54};
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < int'(NR); i++) begin
                ops_a[i] = vecs[v].a;
                ops_b[i] = vecs[v].b;
            end
            apply_ops();
            run_txn(vecs[v].req, vecs[v].keep, vecs[v].lat, vecs[v].hold,
                    vecs[v].exp_id, vecs[v].exp_res, $sformatf("vec%0d", v));
        end

        // Spurious done while idle must not produce a response.
        bus.req          = '0;
        bus.eng_result   = 16'hdead;
        bus.eng_done     = 1'b1;
        tick();
        check("spur_idle0", {bus.rsp_valid, bus.busy, bus.gnt}, 6'b0);
        tick();
        check("spur_idle1", {bus.rsp_valid, bus.busy, bus.gnt}, 6'b0);
        ops_a[1] = 32'h0a0a0a0a;
        ops_b[1] = 32'h01020305;
        apply_ops();
        run_txn(4'b0010, 1'b0, 2, 0, 1, 16'd110, "after_spur");

        // Reset during WAIT for requester 3; late done afterwards is ignored.
        ops_a[3] = 32'h11223344;
        ops_b[3] = 32'h01010101;
        apply_ops();
        eng_lat = 8;
        bus.req = 4'b1000;
        tick();
        check("rst_seq.gnt", 64'(bus.gnt), 64'(4'b1000));
        bus.req = '0;
        tick();
        tick();
        tick();
        check("rst_seq.in_wait", {bus.busy, bus.rsp_valid}, 2'b10);
        rst = 1'b1;
        #1;
        check("rst_seq.async_clear", 64'(any_out()), 64'(0));
        tick();
        rst   = 1'b0;
        ptr_m = 0;
        bad   = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        check("rst_seq.late_done_ignored", 64'(bad), 64'(0));
        ops_a[0] = 32'h02030405;
        ops_b[0] = 32'h06070809;
        apply_ops();
        run_txn(4'b1001, 1'b0, 2, 0, 0, dot(ops_a[0], ops_b[0]), "rst_seq.ptr0");

        // Randomized transactions against the round-robin model.
        pending = bus.req;
        for (int t = 0; t < 40; t++) begin
            newr = pending | 4'($urandom_range(0, 15));
            if (newr == 4'b0000) newr = 4'(1) << $urandom_range(0, 3);
            for (int i = 0; i < int'(NR); i++) begin
                if (!pending[i]) begin
                    ops_a[i] = $urandom;
                    ops_b[i] = $urandom;
                end
            end
            apply_ops();
            id = pick(newr, ptr_m);
            run_txn(newr, 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 3)), id, dot(ops_a[id], ops_b[id]),
                    $sformatf("rnd%0d", t));
            pending = bus.req;
        end

        // Engine that never completes.
        bus.req  = '0;
        eng_auto = 1'b0;
        tick();
        ops_a[2] = 32'h01010101;
        ops_b[2] = 32'h02020202;
        apply_ops();
        bus.req = 4'b0100;
        tick();
        check("to.gnt", 64'(bus.gnt), 64'(4'b0100));
        bus.req = '0;
        tick();
        check("to.start", 64'(bus.eng_start), 64'(1));
`ifdef DOTP_ARB_TIMEOUT_EN
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("to.cycles", 64'(n), 64'(TO));
        check("to.rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err},
              {1'b1, 2'd2, 16'd0, 1'b1});
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("to.hs", {bus.rsp_valid, bus.rsp_err, bus.busy}, 3'b000);
        ptr_m = 3;
        bus.eng_result = 16'h1234;
        bus.eng_done   = 1'b1;
        tick();
        tick();
        check("to.late_done", {bus.rsp_valid, bus.busy}, 2'b00);
`else
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.rsp_valid !== 1'b0) n++;
        end
        check("no_to.no_rsp", 64'(n), 64'(0));
        check("no_to.busy", {bus.busy, bus.rsp_err}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("no_to.recover", 64'(bus.busy), 64'(0));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
